qpd_lockin_mux: RTL and testbench

Time-multiplexed, parametrised lock-in demodulator for NUM_QPD quadrant-photodiode pairs. It sits after the input filters and the Hilbert stage. Per input tick it forms sum and difference of each QPD pair and multiplies both by sin and cos using one shared multiplier. It accumulates over DECIM ticks and presents integrate-and-dump results through a valid/ready handshake. It extends the two-channel demodulator with any channel count, built-in decimation, back-pressure and drop/overrun accounting.

---
 rtl/qpd_lockin_pkg.sv | 36 +++
 rtl/qpd_lockin_mux_if.sv | 33 +++
 rtl/qpd_lockin_mux_lockin_mac.sv | 46 ++++
 rtl/qpd_lockin_mux.sv | 217 +++++++++++++++++++++
 tb/tb_qpd_lockin_mux.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qpd_lockin_pkg.sv
// Shared types and helpers for the multiplexed QPD lock-in demodulator.
package qpd_lockin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DUMP = 2'd2
  } state_t;

  localparam int SAT_W = 64;

  function automatic int prod_width(input int nb);
    return 2 * nb + 1;
  endfunction

  function automatic int acc_width(input int nb, input int decim);
    return prod_width(nb) + $clog2(decim);
  endfunction

  // Clamp a sign-extended value into the signed range of a w-bit word.
  function automatic logic signed [SAT_W-1:0] sat_signed(input logic signed [SAT_W-1:0] x,
                                                          input int w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/qpd_lockin_mux_if.sv
// Sample, reference, result and handshake bundle of qpd_lockin_mux.
interface qpd_lockin_mux_if #(
  parameter int NUM_QPD  = 2,
  parameter int NUM_BITS = 24
);
  logic                               tick_i;
  logic [NUM_QPD-1:0][NUM_BITS-1:0]   qpd_a_i;
  logic [NUM_QPD-1:0][NUM_BITS-1:0]   qpd_b_i;
  logic [NUM_BITS-1:0]                sin_i;
  logic [NUM_BITS-1:0]                cos_i;
  logic                               ready_i;
  logic [NUM_QPD-1:0][NUM_BITS:0]     x_i_o;
  logic [NUM_QPD-1:0][NUM_BITS:0]     x_q_o;
  logic [NUM_QPD-1:0][NUM_BITS:0]     s_i_o;
  logic [NUM_QPD-1:0][NUM_BITS:0]     s_q_o;
  logic                               valid_o;
  logic                               busy_o;
  logic                               overrun_o;
  logic [31:0]                        dump_count_o;
  logic [15:0]                        drop_count_o;

  modport master (
    output tick_i, qpd_a_i, qpd_b_i, sin_i, cos_i, ready_i,
    input  x_i_o, x_q_o, s_i_o, s_q_o, valid_o, busy_o, overrun_o,
           dump_count_o, drop_count_o
  );

  modport slave (
    input  tick_i, qpd_a_i, qpd_b_i, sin_i, cos_i, ready_i,
    output x_i_o, x_q_o, s_i_o, s_q_o, valid_o, busy_o, overrun_o,
           dump_count_o, drop_count_o
  );
endinterface

// File: rtl/qpd_lockin_mux_lockin_mac.sv
// Shared multiplier feeding a bank of 4*NUM_QPD accumulators addressed by {q,k}.
module lockin_mac
  import qpd_lockin_pkg::*;
#(
  parameter int  NUM_QPD  = 2,
  parameter int  NUM_BITS = 24,
  parameter int  DECIM    = 64,
  localparam int NSTEP    = 4 * NUM_QPD,
  localparam int STEP_W   = $clog2(NSTEP),
  localparam int PROD_W   = prod_width(NUM_BITS),
  localparam int ACC_W    = acc_width(NUM_BITS, DECIM)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_en,
  input  logic                       i_clr,
  input  logic [STEP_W-1:0]          i_sel,
  input  logic signed [NUM_BITS:0]   i_op_a,
  input  logic signed [NUM_BITS-1:0] i_op_b,
  output logic signed [ACC_W-1:0]    o_acc [NSTEP]
);

  logic signed [PROD_W-1:0] w_a_ext;
  logic signed [PROD_W-1:0] w_b_ext;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  r_acc [NSTEP];

  assign w_a_ext = PROD_W'(i_op_a);
  assign w_b_ext = PROD_W'(i_op_b);
  // The full-width product always fits PROD_W bits, so truncation is exact.
  assign w_prod  = w_a_ext * w_b_ext;

  // Accumulator bank: clear on dump, otherwise add the current product.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      for (int i = 0; i < NSTEP; i++) begin
        r_acc[i] <= '0;
      end
    end else if (i_en) begin
      r_acc[i_sel] <= r_acc[i_sel] + ACC_W'(w_prod);
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/qpd_lockin_mux.sv
// Time-multiplexed integrate-and-dump lock-in demodulator for NUM_QPD QPD pairs.
// Define QPD_LOCKIN_SATURATE_EN to saturate (instead of truncate) the dumped averages.
module qpd_lockin_mux
  import qpd_lockin_pkg::*;
#(
  parameter int NUM_QPD  = 2,
  parameter int NUM_BITS = 24,
  parameter int DECIM    = 64
) (
  input  logic            clk,
  input  logic            reset,
  qpd_lockin_mux_if.slave bus
);

  localparam int NSTEP  = 4 * NUM_QPD;
  localparam int STEP_W = $clog2(NSTEP);
  localparam int TCNT_W = $clog2(DECIM);
  localparam int OUT_W  = NUM_BITS + 1;
  localparam int WIDE_W = NUM_BITS + 2;
  localparam int ACC_W  = acc_width(NUM_BITS, DECIM);
  localparam int SHIFT  = NUM_BITS - 1 + TCNT_W;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NSTEP - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(DECIM - 1);

  state_t                      r_state;
  state_t                      w_next;
  logic                        w_accept;
  logic                        w_mac_en;
  logic                        w_last;
  logic                        w_dump;
  logic                        w_load;
  logic [STEP_W-1:0]           r_step;
  logic [STEP_W-1:0]           w_qidx;
  logic [TCNT_W-1:0]           r_tick_cnt;
  logic signed [OUT_W-1:0]     w_diff [NUM_QPD];
  logic signed [OUT_W-1:0]     w_sum  [NUM_QPD];
  logic signed [OUT_W-1:0]     r_diff [NUM_QPD];
  logic signed [OUT_W-1:0]     r_sum  [NUM_QPD];
  logic signed [NUM_BITS-1:0]  r_sin;
  logic signed [NUM_BITS-1:0]  r_cos;
  logic signed [OUT_W-1:0]     w_op_a;
  logic signed [NUM_BITS-1:0]  w_op_b;
  logic signed [ACC_W-1:0]     w_acc [NSTEP];
  logic [OUT_W-1:0]            w_res [NSTEP];
  logic [NUM_QPD-1:0][OUT_W-1:0] r_x_i;
  logic [NUM_QPD-1:0][OUT_W-1:0] r_x_q;
  logic [NUM_QPD-1:0][OUT_W-1:0] r_s_i;
  logic [NUM_QPD-1:0][OUT_W-1:0] r_s_q;
  logic                        r_valid;
  logic                        r_overrun;
  logic [31:0]                 r_dump_cnt;
  logic [15:0]                 r_drop_cnt;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_mac_en = 1'b0;
    w_last   = 1'b0;
    w_dump   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.tick_i) begin
          w_accept = 1'b1;
          w_next   = ST_CALC;
        end else begin
          w_next   = ST_IDLE;
        end
      end
      ST_CALC: begin
        w_mac_en = 1'b1;
        if (r_step == STEP_LAST) begin
          w_last = 1'b1;
          w_next = (r_tick_cnt == TCNT_LAST) ? ST_DUMP : ST_IDLE;
        end else begin
          w_next = ST_CALC;
        end
      end
      ST_DUMP: begin
        w_dump = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
    w_load = w_dump && (!r_valid || bus.ready_i);
  end

  // Negated sum/difference per pair, saturated into NUM_BITS+1 bits.
  always_comb begin
    for (int q = 0; q < NUM_QPD; q++) begin
      w_sum[q]  = OUT_W'(sat_signed(SAT_W'(-(WIDE_W'($signed(bus.qpd_a_i[q]))
                                           + WIDE_W'($signed(bus.qpd_b_i[q])))), OUT_W));
      w_diff[q] = OUT_W'(sat_signed(SAT_W'(-(WIDE_W'($signed(bus.qpd_a_i[q]))
                                           - WIDE_W'($signed(bus.qpd_b_i[q])))), OUT_W));
    end
  end

  // Input latch, step counter and tick counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_step     <= '0;
      r_tick_cnt <= '0;
      r_sin      <= '0;
      r_cos      <= '0;
      for (int q = 0; q < NUM_QPD; q++) begin
        r_sum[q]  <= '0;
        r_diff[q] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_step <= '0;
        r_sin  <= $signed(bus.sin_i);
        r_cos  <= $signed(bus.cos_i);
        r_sum  <= w_sum;
        r_diff <= w_diff;
      end else if (w_mac_en) begin
        r_step <= r_step + STEP_W'(1);
      end
      if (w_last) begin
        r_tick_cnt <= (r_tick_cnt == TCNT_LAST) ? '0 : r_tick_cnt + TCNT_W'(1);
      end
    end
  end

  // Step order per pair: diff*sin, diff*cos, sum*sin, sum*cos.
  always_comb begin
    w_qidx = r_step >> 2;
    w_op_b = r_step[0] ? r_cos : r_sin;
    w_op_a = '0;
    for (int q = 0; q < NUM_QPD; q++) begin
      w_op_a = (w_qidx == STEP_W'(q)) ? (r_step[1] ? r_sum[q] : r_diff[q]) : w_op_a;
    end
  end

  lockin_mac #(
    .NUM_QPD  (NUM_QPD),
    .NUM_BITS (NUM_BITS),
    .DECIM    (DECIM)
  ) u_mac (
    .clk    (clk),
    .reset  (reset),
    .i_en   (w_mac_en),
    .i_clr  (w_dump),
    .i_sel  (r_step),
    .i_op_a (w_op_a),
    .i_op_b (w_op_b),
    .o_acc  (w_acc)
  );

  // Floor-shifted averages of every accumulator.
  always_comb begin
    for (int i = 0; i < NSTEP; i++) begin
`ifdef QPD_LOCKIN_SATURATE_EN
      w_res[i] = OUT_W'(sat_signed(SAT_W'(w_acc[i] >>> SHIFT), OUT_W));
`else
      w_res[i] = OUT_W'(w_acc[i] >>> SHIFT);
`endif
    end
  end

  // Result registers, handshake and accounting.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x_i      <= '0;
      r_x_q      <= '0;
      r_s_i      <= '0;
      r_s_q      <= '0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
      r_dump_cnt <= 32'd0;
      r_drop_cnt <= 16'd0;
    end else begin
      if (w_load) begin
        for (int q = 0; q < NUM_QPD; q++) begin
          r_x_i[q] <= w_res[4*q];
          r_x_q[q] <= w_res[4*q+1];
          r_s_i[q] <= w_res[4*q+2];
          r_s_q[q] <= w_res[4*q+3];
        end
        r_valid <= 1'b1;
      end else if (r_valid && bus.ready_i) begin
        r_valid <= 1'b0;
      end
      if (w_dump && r_valid && !bus.ready_i) begin
        r_overrun <= 1'b1;
      end
      if (w_dump) begin
        r_dump_cnt <= r_dump_cnt + 32'd1;
      end
      if (bus.tick_i && (r_state != ST_IDLE) && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign bus.x_i_o        = r_x_i;
  assign bus.x_q_o        = r_x_q;
  assign bus.s_i_o        = r_s_i;
  assign bus.s_q_o        = r_s_q;
  assign bus.valid_o      = r_valid;
  assign bus.busy_o       = (r_state != ST_IDLE);
  assign bus.overrun_o    = r_overrun;
  assign bus.dump_count_o = r_dump_cnt;
  assign bus.drop_count_o = r_drop_cnt;

endmodule

// File: tb/tb_qpd_lockin_mux.sv
// Directed and randomized bench for qpd_lockin_mux (NUM_QPD=2, NUM_BITS=24, DECIM=4)
// against an arithmetic reference model of the lock-in averages and handshake.
module tb_qpd_lockin_mux;

  localparam int NQ    = 2;
  localparam int NB    = 24;
  localparam int DEC   = 4;
  localparam int NSTEP = 4 * NQ;
  localparam int SHIFT = NB - 1 + 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  qpd_lockin_mux_if #(.NUM_QPD(NQ), .NUM_BITS(NB)) bus_if ();

  qpd_lockin_mux #(.NUM_QPD(NQ), .NUM_BITS(NB), .DECIM(DEC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int     n_cmp  = 0;
  int     n_fail = 0;
  longint m_acc [NQ][4];
  longint m_out [NQ][4];
  int     m_tcnt;
  int     m_dumps;
  int     m_drops;
  bit     m_valid;
  bit     m_overrun;
  bit     m_dump_due;
  logic signed [NB-1:0] t_a [NQ];
  logic signed [NB-1:0] t_b [NQ];
  logic signed [NB-1:0] t_s;
  logic signed [NB-1:0] t_c;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint clamp25(input longint v);
    if (v > 64'sd16777215) return 64'sd16777215;
    else if (v < -64'sd16777216) return -64'sd16777216;
    else return v;
  endfunction

  function automatic longint fit25(input longint v);
    longint r;
`ifdef QPD_LOCKIN_SATURATE_EN
    r = clamp25(v);
`else
    r = v & 64'sh1FFFFFF;
    if (r >= 64'sd16777216) r = r - 64'sd33554432;
`endif
    return r;
  endfunction

  function automatic logic signed [63:0] get_out(input int q, input int k);
    case (k)
      0:       return 64'($signed(bus_if.x_i_o[q]));
      1:       return 64'($signed(bus_if.x_q_o[q]));
      2:       return 64'($signed(bus_if.s_i_o[q]));
      3:       return 64'($signed(bus_if.s_q_o[q]));
      default: return 64'sd0;
    endcase
  endfunction

  function automatic logic signed [NB-1:0] rnd();
    case ($urandom_range(0, 3))
      0:       return 24'sh800000;
      1:       return 24'sh7FFFFF;
      default: return 24'($urandom);
    endcase
  endfunction

  task automatic model_reset();
    for (int q = 0; q < NQ; q++)
      for (int k = 0; k < 4; k++) begin
        m_acc[q][k] = 0;
        m_out[q][k] = 0;
      end
    m_tcnt = 0; m_dumps = 0; m_drops = 0;
    m_valid = 0; m_overrun = 0; m_dump_due = 0;
  endtask

  task automatic model_accept();
    longint a, b, s, d;
    for (int q = 0; q < NQ; q++) begin
      a = longint'(t_a[q]);
      b = longint'(t_b[q]);
      s = clamp25(-(a + b));
      d = clamp25(-(a - b));
      m_acc[q][0] += d * longint'(t_s);
      m_acc[q][1] += d * longint'(t_c);
      m_acc[q][2] += s * longint'(t_s);
      m_acc[q][3] += s * longint'(t_c);
    end
    m_tcnt++;
    if (m_tcnt == DEC) begin
      m_tcnt = 0;
      m_dump_due = 1;
    end
  endtask

  task automatic model_dump(input bit rdy);
    if (!m_valid || rdy) begin
      for (int q = 0; q < NQ; q++)
        for (int k = 0; k < 4; k++)
          m_out[q][k] = fit25(m_acc[q][k] >>> SHIFT);
      m_valid = 1;
    end else begin
      m_overrun = 1;
    end
    for (int q = 0; q < NQ; q++)
      for (int k = 0; k < 4; k++)
        m_acc[q][k] = 0;
    m_dumps++;
    m_dump_due = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_valid"}, bus_if.valid_o, m_valid);
    chk({tag, "_overrun"}, bus_if.overrun_o, m_overrun);
    chk({tag, "_dumps"}, bus_if.dump_count_o, m_dumps);
    chk({tag, "_drops"}, bus_if.drop_count_o, m_drops);
    for (int q = 0; q < NQ; q++)
      for (int k = 0; k < 4; k++)
        chk($sformatf("%s_out_q%0d_k%0d", tag, q, k), get_out(q, k), m_out[q][k]);
  endtask

  task automatic scramble();
    for (int q = 0; q < NQ; q++) begin
      bus_if.qpd_a_i[q] = 24'($urandom);
      bus_if.qpd_b_i[q] = 24'($urandom);
    end
    bus_if.sin_i = 24'($urandom);
    bus_if.cos_i = 24'($urandom);
  endtask

  task automatic drive();
    for (int q = 0; q < NQ; q++) begin
      bus_if.qpd_a_i[q] = t_a[q];
      bus_if.qpd_b_i[q] = t_b[q];
    end
    bus_if.sin_i = t_s;
    bus_if.cos_i = t_c;
  endtask

  task automatic randomize_inputs();
    for (int q = 0; q < NQ; q++) begin
      t_a[q] = rnd();
      t_b[q] = rnd();
    end
    t_s = rnd();
    t_c = rnd();
  endtask

  // One accepted tick, then 'gap' further edges; drop_at>0 pulses an extra tick mid-calculation.
  task automatic send_tick(input int gap, input int drop_at);
    drive();
    bus_if.tick_i = 1'b1;
    @(posedge clk); #1;
    bus_if.tick_i = 1'b0;
    scramble();
    model_accept();
    chk("busy_after_accept", bus_if.busy_o, 1);
    for (int c = 1; c <= gap; c++) begin
      bus_if.tick_i = (c == drop_at);
      @(posedge clk); #1;
      bus_if.tick_i = 1'b0;
      if (c == drop_at && m_drops < 65535) m_drops++;
      if (m_dump_due && c == NSTEP) begin
        chk("valid_before_dump", bus_if.valid_o, m_valid);
      end else if (m_dump_due && c == NSTEP + 1) begin
        model_dump(bus_if.ready_i);
        check_all("dump");
      end
    end
    chk("busy_idle", bus_if.busy_o, 0);
    chk("drop_count", bus_if.drop_count_o, m_drops);
  endtask

  task automatic run_block(input bit rnd_in, input bit rnd_gap);
    int gap;
    for (int i = 0; i < DEC; i++) begin
      if (rnd_in) randomize_inputs();
      if (rnd_gap) gap = (m_tcnt == DEC - 1) ? $urandom_range(NSTEP + 1, 12) : $urandom_range(NSTEP, 12);
      else gap = 11;
      send_tick(gap, 0);
    end
  endtask

  task automatic consume();
    bus_if.ready_i = 1'b1;
    @(posedge clk); #1;
    bus_if.ready_i = 1'b0;
    m_valid = 0;
    chk("consume_valid", bus_if.valid_o, 0);
    chk("consume_overrun", bus_if.overrun_o, m_overrun);
  endtask

  task automatic set_pair(input int q, input logic signed [NB-1:0] a, input logic signed [NB-1:0] b);
    t_a[q] = a;
    t_b[q] = b;
  endtask

  initial begin
    bus_if.tick_i  = 1'b0;
    bus_if.ready_i = 1'b0;
    scramble();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_all("reset");
    chk("reset_busy", bus_if.busy_o, 0);

    set_pair(0, 24'sd1000, 24'sd0);
    set_pair(1, 24'sd0, 24'sd0);
    t_s = 24'sd8388607;
    t_c = 24'sd0;
    run_block(1'b0, 1'b0);
    chk("s1_x_i0", get_out(0, 0), -64'sd1000);
    chk("s1_s_i0", get_out(0, 2), -64'sd1000);
    chk("s1_x_q0", get_out(0, 1), 64'sd0);
    consume();

    set_pair(0, 24'sd0, 24'sd0);
    set_pair(1, -24'sd500, 24'sd500);
    t_s = 24'sd0;
    t_c = -24'sd8388608;
    run_block(1'b0, 1'b0);
    chk("s2_x_q1", get_out(1, 1), -64'sd1000);
    chk("s2_s_q1", get_out(1, 3), 64'sd0);
    consume();

    set_pair(0, -24'sd8388608, -24'sd8388608);
    set_pair(1, 24'sd0, 24'sd0);
    t_s = -24'sd8388608;
    t_c = 24'sd0;
    run_block(1'b0, 1'b0);
    consume();

    run_block(1'b1, 1'b0);
    run_block(1'b1, 1'b0);
    chk("overrun_set", bus_if.overrun_o, 1);
    consume();

    randomize_inputs();
    send_tick(11, 3);
    for (int i = 1; i < DEC; i++) begin
      randomize_inputs();
      send_tick(11, 0);
    end
    chk("drop_one", bus_if.drop_count_o, 1);
    consume();

    for (int r = 0; r < 3; r++) begin
      run_block(1'b1, 1'b1);
      consume();
    end

    randomize_inputs();
    send_tick(11, 0);
    randomize_inputs();
    drive();
    bus_if.tick_i = 1'b1;
    @(posedge clk); #1;
    bus_if.tick_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    chk("midreset_busy", bus_if.busy_o, 0);
    check_all("midreset");

    set_pair(0, 24'sd1000, 24'sd0);
    set_pair(1, 24'sd0, 24'sd0);
    t_s = 24'sd8388607;
    t_c = 24'sd0;
    run_block(1'b0, 1'b0);
    chk("rerun_x_i0", get_out(0, 0), -64'sd1000);
    chk("rerun_s_i0", get_out(0, 2), -64'sd1000);
    chk("rerun_dumps", bus_if.dump_count_o, 1);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
